// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- control-side sequencer for the 8-bit 74-series ALU netlist.
//
// Owns the A/B operand registers. Turns one start/op command into the
// multi-cycle strobe sequence the ALU needs: ADD, SUB, or an N-step shift
// right through the ALU shift flag (9-bit rotate of {flagShift, areg}).
// Results are captured from the shared data bus.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, op, count  command strobe (IDLE only), opcode, shift steps minus 1
//   a_in, b_in        operands latched on an accepted start
//   busy, done        not-IDLE indicator, one-cycle completion pulse
//   result            last captured result (held until the next FIN)
//   carry, zero       copies of the ALU flagCarry / aIsZero
//   areg, breg        ALU operand inputs
//   doSubtract        ALU subtract select
//   assertBarE/S      active-low ALU-output / shifter bus enables
//   triggerC/S        carry-flag / shift-flag capture clocks
//   dbus              shared data bus
//   flagCarry, flagShift, aIsZero   ALU status inputs
//
// Optional feature macro: ALU_SEQ_TRACE_EN (simulation-only trace and
// start-time enable check; no effect on function or timing).
// -----------------------------------------------------------------------------
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] count,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic [7:0] areg,
    output logic [7:0] breg,
    output logic       doSubtract,
    output logic       assertBarE,
    output logic       assertBarS,
    output logic       triggerC,
    output logic       triggerS,
    input  logic [7:0] dbus,
    input  logic       flagCarry,
    input  logic       flagShift,
    input  logic       aIsZero
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        E_DRV = 3'd1,
        E_TRG = 3'd2,
        S_DRV = 3'd3,
        S_TRG = 3'd4,
        S_WB  = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] areg_q, areg_d;
    logic [7:0] breg_q, breg_d;
    logic [7:0] result_q, result_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] step_q, step_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       dosub_q, dosub_d;
    logic       bar_e_q, bar_e_d;
    logic       bar_s_q, bar_s_d;
    logic       trg_c_q, trg_c_d;
    logic       trg_s_q, trg_s_d;

    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        result_d = result_q;
        hold_d   = hold_q;
        step_d   = step_q;
        dosub_d  = dosub_q;
        bar_e_d  = bar_e_q;
        bar_s_d  = bar_s_q;
        trg_c_d  = trg_c_q;
        trg_s_d  = trg_s_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    areg_d  = a_in;
                    breg_d  = b_in;
                    dosub_d = (op == 2'b01);
                    if (!op[1]) begin
                        bar_e_d = 1'b0;
                        state_d = E_DRV;
                    end else begin
                        // op 11 is reserved and runs as a shift
                        step_d  = count;
                        bar_s_d = 1'b0;
                        state_d = S_DRV;
                    end
                end
            end
            E_DRV: begin
                result_d = dbus;
                trg_c_d  = 1'b1;
                bar_e_d  = 1'b1;
                state_d  = E_TRG;
            end
            E_TRG: begin
                trg_c_d = 1'b0;
                state_d = FIN;
            end
            S_DRV: begin
                // areg is still the old value, so the shift flag captures
                // the bit being shifted out.
                hold_d  = dbus;
                bar_s_d = 1'b1;
                trg_s_d = 1'b1;
                state_d = S_TRG;
            end
            S_TRG: begin
                trg_s_d = 1'b0;
                state_d = S_WB;
            end
            S_WB: begin
                areg_d = hold_q;
                if (step_q != 3'd0) begin
                    step_d  = step_q - 3'd1;
                    bar_s_d = 1'b0;
                    state_d = S_DRV;
                end else begin
                    result_d = hold_q;
                    state_d  = FIN;
                end
            end
            FIN: begin
                dosub_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            areg_q   <= 8'h00;
            breg_q   <= 8'h00;
            result_q <= 8'h00;
            hold_q   <= 8'h00;
            step_q   <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dosub_q  <= 1'b0;
            bar_e_q  <= 1'b1;
            bar_s_q  <= 1'b1;
            trg_c_q  <= 1'b0;
            trg_s_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            result_q <= result_d;
            hold_q   <= hold_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dosub_q  <= dosub_d;
            bar_e_q  <= bar_e_d;
            bar_s_q  <= bar_s_d;
            trg_c_q  <= trg_c_d;
            trg_s_q  <= trg_s_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign carry      = flagCarry;
    assign zero       = aIsZero;
    assign areg       = areg_q;
    assign breg       = breg_q;
    assign doSubtract = dosub_q;
    assign assertBarE = bar_e_q;
    assign assertBarS = bar_s_q;
    assign triggerC   = trg_c_q;
    assign triggerS   = trg_s_q;

`ifdef ALU_SEQ_TRACE_EN
`ifndef SYNTHESIS
    // Operands as latched at start; areg itself is rewritten by shifts.
    logic [1:0] tr_op_q;
    logic [7:0] tr_a_q;
    logic [7:0] tr_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tr_op_q <= 2'b00;
            tr_a_q  <= 8'h00;
            tr_b_q  <= 8'h00;
        end else if (state_q == IDLE && start) begin
            tr_op_q <= op;
            tr_a_q  <= a_in;
            tr_b_q  <= b_in;
            if (!(bar_e_q && bar_s_q))
                $display("%0t alu_seq error: bus enable active at start", $time);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == FIN)
            $display("%0t alu_seq: op=%0d a=%02h b=%02h result=%02h carry=%0b flagShift=%0b",
                     $time, tr_op_q, tr_a_q, tr_b_q, result_q, flagCarry, flagShift);
    end
`endif
`endif

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed testbench for alu_seq. Contains a behavioural model
// of the ALU netlist (adder/subtractor, shifter, bus drive, carry and shift
// flag flops) so the sequencer can be exercised against its real partner.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [2:0] count;
    logic [7:0] a_in, b_in;
    logic       busy, done;
    logic [7:0] result;
    logic       carry, zero;
    logic [7:0] areg, breg;
    logic       doSubtract, assertBarE, assertBarS, triggerC, triggerS;
    logic [7:0] dbus;
    logic       flagCarry, flagShift, aIsZero;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .count(count),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
        .carry(carry), .zero(zero), .areg(areg), .breg(breg),
        .doSubtract(doSubtract), .assertBarE(assertBarE), .assertBarS(assertBarS),
        .triggerC(triggerC), .triggerS(triggerS), .dbus(dbus),
        .flagCarry(flagCarry), .flagShift(flagShift), .aIsZero(aIsZero)
    );

    // ALU model
    logic [8:0] sum9;
    assign sum9    = {1'b0, areg} + {1'b0, (doSubtract ? ~breg : breg)} + {8'd0, doSubtract};
    assign dbus    = !assertBarE ? sum9[7:0] :
                     !assertBarS ? {flagShift, areg[7:1]} : 8'h00;
    assign aIsZero = (areg == 8'h00);

    always @(posedge triggerC or posedge reset)
        if (reset) flagCarry <= 1'b0;
        else       flagCarry <= sum9[8];

    always @(posedge triggerS or posedge reset)
        if (reset) flagShift <= 1'b0;
        else       flagShift <= areg[0];

    // Monitors: only ever incremented here; the sequence takes differences.
    int e_low_cnt   = 0;
    int both_low    = 0;
    int done_cnt    = 0;
    int trg_s_cnt   = 0;

    always @(negedge clk) begin
        if (!assertBarE) e_low_cnt++;
        if (!assertBarE && !assertBarS) both_low++;
        if (done === 1'b1) done_cnt++;
    end

    always @(posedge triggerS) trg_s_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; returns sampled in the first busy cycle.
    task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] c);
        op = o; a_in = a; b_in = b; count = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until done is seen (bounded); n = ticks after the first busy cycle.
    task automatic to_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
    endtask

    int n, e0, b0, d0, t0;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; count = 3'd0; a_in = 8'h00; b_in = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_areg",  areg, 8'h00);
        chk("rst_breg",  breg, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_dosub", doSubtract, 0);
        chk("rst_bars",  {assertBarE, assertBarS, triggerC, triggerS}, 4'b1100);
        chk("rst_zero",  zero, 1);
        reset = 1'b0;
        tick();

        // ADD 3C+05
        e0 = e_low_cnt;
        issue(2'b00, 8'h3C, 8'h05, 3'd0);
        chk("add_busy", busy, 1);
        to_done(n);
        chk("add_done_seen", done, 1);
        chk("add_latency", n, 2);
        chk("add_result", result, 8'h41);
        chk("add_carry", carry, 0);
        chk("add_ebar_cycles", e_low_cnt - e0, 1);
        chk("add_areg_kept", areg, 8'h3C);
        tick();
        chk("add_done_pulse", done, 0);
        chk("add_idle", busy, 0);

        // SUB 10-01
        issue(2'b01, 8'h10, 8'h01, 3'd0);
        chk("sub1_dosub", doSubtract, 1);
        to_done(n);
        chk("sub1_done_seen", done, 1);
        chk("sub1_result", result, 8'h0F);
        chk("sub1_carry", carry, 1);
        tick();

        // SUB 05-06 borrows
        issue(2'b01, 8'h05, 8'h06, 3'd0);
        to_done(n);
        chk("sub2_done_seen", done, 1);
        chk("sub2_result", result, 8'hFF);
        chk("sub2_carry", carry, 0);
        tick();
        chk("sub2_dosub_cleared", doSubtract, 0);

        // SHR single steps, flagShift cleared by reset
        reset = 1'b1; #1; reset = 1'b0;
        tick();
        issue(2'b10, 8'h81, 8'h00, 3'd0);
        to_done(n);
        chk("shr1_done_seen", done, 1);
        chk("shr1_latency", n, 3);
        chk("shr1_result", result, 8'h40);
        chk("shr1_flag", flagShift, 1);
        tick();
        issue(2'b10, 8'h00, 8'h00, 3'd0);
        to_done(n);
        chk("shr2_result", result, 8'h80);
        chk("shr2_flag", flagShift, 0);
        tick();

        // SHR 8 steps of A5 with flag 0 (reserved op 11 behaves the same)
        b0 = both_low; t0 = trg_s_cnt;
        issue(2'b11, 8'hA5, 8'h00, 3'd7);
        to_done(n);
        chk("shr8_done_seen", done, 1);
        chk("shr8_busy_cycles", n + 1, 25);
        chk("shr8_result", result, 8'h4A);
        chk("shr8_areg", areg, 8'h4A);
        chk("shr8_flag", flagShift, 1);
        chk("shr8_trg_pulses", trg_s_cnt - t0, 8);
        chk("shr8_enables_overlap", both_low - b0, 0);
        tick();

        // start held high through an 8-step SHR with a_in changing
        d0 = done_cnt;
        op = 2'b10; a_in = 8'h01; count = 3'd7; start = 1'b1;
        tick();
        a_in = 8'hFF; op = 2'b00;
        to_done(n);
        chk("hold_done_seen", done, 1);
        chk("hold_busy_cycles", n + 1, 25);
        chk("hold_result", result, 8'h03);
        chk("hold_flag", flagShift, 0);
        tick();                      // start was high at the FIN edge
        start = 1'b0;
        chk("hold_fin_ignored", busy, 0);
        chk("hold_areg", areg, 8'h03);
        tick();
        chk("hold_single_done", done_cnt - d0, 1);
        issue(2'b00, 8'h01, 8'h02, 3'd0);
        chk("hold_next_accept", busy, 1);
        to_done(n);
        chk("hold_next_result", result, 8'h03);
        tick();

        // Reset during 5th busy cycle of an 8-step SHR
        issue(2'b10, 8'hA5, 8'h00, 3'd7);
        tick(); tick(); tick(); tick();
        chk("mid_busy_before", busy, 1);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_areg", areg, 8'h00);
        chk("mid_ctrl", {assertBarE, assertBarS, triggerC, triggerS}, 4'b1100);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("mid_no_done", done_cnt - d0, 0);
        issue(2'b00, 8'hF0, 8'h20, 3'd0);
        to_done(n);
        chk("post_add_latency", n, 2);
        chk("post_add_result", result, 8'h10);
        chk("post_add_carry", carry, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Control-side sequencer for the 8-bit ALU netlist. It owns the A and B operand registers and drives the ALU's bus-assert enables and flag triggers. It captures ALU or shifter output from the shared data bus and writes it back as a result. It turns a single start/op command into the multi-cycle strobe sequence the 74-series ALU needs: add, subtract, or N-step shift through the shift flag.

Parameters:
None. Widths are fixed at 8-bit data and 3-bit shift count.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; also feeds the ALU flag flops
start  in  1  command strobe, sampled in IDLE only
op  in  2  00=ADD, 01=SUB, 10=SHR (shift right through flagShift), 11=reserved (treated as SHR)
count  in  3  SHR step count minus 1 (0 means 1 step, 7 means 8 steps)
a_in  in  8  A operand, loaded on accepted start
b_in  in  8  B operand, loaded on accepted start
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse in FIN
result  out  8  last captured result, held until next FIN
carry  out  1  copy of flagCarry
zero  out  1  copy of aIsZero
areg  out  8  to ALU A input
breg  out  8  to ALU B input
doSubtract  out  1  to ALU
assertBarE  out  1  active-low ALU-output bus enable
assertBarS  out  1  active-low shifter bus enable
triggerC  out  1  carry-flag clock (rising edge captures)
triggerS  out  1  shift-flag clock (rising edge captures areg[0])
dbus  in  8  shared data bus
flagCarry  in  1  from ALU
flagShift  in  1  from ALU
aIsZero  in  1  from ALU

Behaviour:
- Reset values: state=IDLE, areg=0, breg=0, result=0, hold=0, step=0, busy=0, done=0, doSubtract=0, assertBarE=1, assertBarS=1, triggerC=0, triggerS=0.
- All control outputs are registered, with no combinational path from start or op.
- States: IDLE, E_DRV, E_TRG, S_DRV, S_TRG, S_WB, FIN.
- IDLE, start=1: areg<=a_in, breg<=b_in, doSubtract<=(op==01).
  - ADD or SUB: go to E_DRV with assertBarE<=0.
  - SHR: step<=count and go to S_DRV with assertBarS<=0.
- IDLE, start=0: no change.
- E_DRV: result<=dbus; triggerC<=1; assertBarE<=1; go to E_TRG.
- E_TRG: triggerC<=0; doSubtract held; go to FIN.
- S_DRV: hold<=dbus; assertBarS<=1; triggerS<=1; go to S_TRG. The flag captures the old areg[0] because areg is unchanged.
- S_TRG: triggerS<=0; go to S_WB.
- S_WB: areg<=hold.
  - step!=0: step<=step-1, assertBarS<=0, go to S_DRV.
  - step==0: result<=hold and go to FIN.
- FIN: done=1; doSubtract<=0; go to IDLE.
- ADD/SUB latency: start accepted at edge N; done high in cycle N+3 (3 busy cycles).
- SHR latency: 3*(count+1)+1 busy cycles.
- areg is not modified by ADD or SUB.
- Enables: assertBarE and assertBarS are never both low in the same cycle. Both are high in IDLE and FIN.
- Triggers: each trigger is high for exactly one cycle per step. No trigger rises in the same cycle that areg changes.
- start while busy is ignored, with no queueing. start in the FIN cycle is also ignored, so the next accept is at the earliest one cycle after done.
- Arithmetic:
  - SUB = A + ~B + 1 in the ALU.
  - After SUB, carry=1 means no borrow.
  - After ADD, carry=1 means an 8-bit overflow out.
- SHR is a 9-bit rotate of {flagShift, areg} by count+1. flagShift is not cleared at start.
- Reset asserted mid-operation: state returns to IDLE immediately (asynchronously), all outputs take reset values, and no done pulse is produced.

Optional Feature:
ALU_SEQ_TRACE_EN
- Defined: in simulation only, $display on every FIN showing time, op, a_in/b_in as latched, result, carry, flagShift.
- Defined: on every accepted start, a check that assertBarE and assertBarS are both high, with a $display error if not.
- Undefined: no display or check code is compiled. Function and timing are identical either way.

Test Plan:
- ADD: reset, start op=00 a=0x3C b=0x05 -> result=0x41, carry=0, done exactly 3 cycles after accept, assertBarE low for exactly 1 cycle.
- SUB: start op=01 a=0x10 b=0x01 -> result=0x0F, carry=1. Then a=0x05 b=0x06 -> result=0xFF, carry=0, doSubtract=0 after FIN.
- SHR single: after reset (flagShift=0), op=10 a=0x81 count=0 -> result=0x40, flagShift=1. Then op=10 a=0x00 count=0 -> result=0x80, flagShift=0.
- SHR full: flagShift=0, op=10 a=0xA5 count=7 -> result=0x4A, flagShift=1, 25 busy cycles, 8 triggerS pulses, never both enables low.
- Busy ignore: start held high throughout an 8-step SHR with different a_in -> only one operation runs. A new op is accepted only once start is sampled high in IDLE.
- Reset mid-SHR: assert reset during the 5th busy cycle -> busy=0, areg=0, enables high and triggers low immediately, no done. A subsequent ADD works normally.
